// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// FWFT or registered-read output, synchronous flush and sticky error flags.
module sync_fifo_flags #(
   parameter int Data_Width = 8,
   parameter int Addr_Width = 4,
   parameter int AF_Level   = 12,
   parameter int AE_Level   = 2,
   parameter int FWFT       = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  clr_err,
   input  logic                  winc,
   input  logic [Data_Width-1:0] wdata,
   input  logic                  rinc,
   output logic [Data_Width-1:0] rdata,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [Addr_Width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int Depth = 1 << Addr_Width;
   localparam logic [Addr_Width:0] L_DEPTH = (Addr_Width+1)'(Depth);
   localparam logic [Addr_Width:0] L_AF    = (Addr_Width+1)'(AF_Level);
   localparam logic [Addr_Width:0] L_AE    = (Addr_Width+1)'(AE_Level);
   localparam logic [Addr_Width:0] L_ONE   = (Addr_Width+1)'(1);

   logic [Data_Width-1:0] r_mem [Depth];
   logic [Addr_Width:0]   r_wptr, r_rptr, r_count;
   logic [Data_Width-1:0] r_rdata;
   logic                  r_ovf, r_udf;
   logic                  w_full, w_empty, w_wr_en, w_rd_en, w_ovf_evt, w_udf_evt;
   logic [Addr_Width-1:0] w_waddr, w_raddr;

   assign w_full    = (r_count == L_DEPTH);
   assign w_empty   = (r_count == '0);
   assign w_wr_en   = winc && !w_full && !flush;
   assign w_rd_en   = rinc && !w_empty && !flush;
   assign w_ovf_evt = winc && w_full && !flush;
   assign w_udf_evt = rinc && w_empty && !flush;
   assign w_waddr   = r_wptr[Addr_Width-1:0];
   assign w_raddr   = r_rptr[Addr_Width-1:0];

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_en) r_wptr <= r_wptr + L_ONE;
         if (w_rd_en) r_rptr <= r_rptr + L_ONE;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + L_ONE;
            2'b01:   r_count <= r_count - L_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Holds the most recently consumed word; in FWFT mode it is shown while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_rdata <= '0;
      else if (w_rd_en) r_rdata <= r_mem[w_raddr];
   end

   // A new error event takes priority over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_ovf_evt)    r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;
         if (w_udf_evt)    r_udf <= 1'b1;
         else if (clr_err) r_udf <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata = w_empty ? r_rdata : r_mem[w_raddr];
      end else begin : g_reg
         assign rdata = r_rdata;
      end
   endgenerate

   assign wfull         = w_full;
   assign rempty        = w_empty;
   assign walmost_full  = (r_count >= L_AF);
   assign ralmost_empty = (r_count <= L_AE);
   assign count         = r_count;
   assign overflow      = r_ovf;
   assign underflow     = r_udf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives an FWFT and a registered-read instance with identical stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_sync_fifo_flags;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0, clr_err = 1'b0, winc = 1'b0, rinc = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata_f, rdata_r;
   logic       wfull_f, wafull_f, rempty_f, raempty_f, ovf_f, udf_f;
   logic       wfull_r, wafull_r, rempty_r, raempty_r, ovf_r, udf_r;
   logic [4:0] count_f, count_r;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic [7:0] m_last = '0;
   bit         m_ovf = 0, m_udf = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
      .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata_f),
      .wfull(wfull_f), .walmost_full(wafull_f), .rempty(rempty_f),
      .ralmost_empty(raempty_f), .count(count_f),
      .overflow(ovf_f), .underflow(udf_f));

   sync_fifo_flags #(.FWFT(0)) u_reg (
      .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
      .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata_r),
      .wfull(wfull_r), .walmost_full(wafull_r), .rempty(rempty_r),
      .ralmost_empty(raempty_r), .count(count_r),
      .overflow(ovf_r), .underflow(udf_r));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count_f", 32'(count_f), 32'(n));
      chk("count_r", 32'(count_r), 32'(n));
      chk("rempty", {30'd0, rempty_f, rempty_r}, {30'd0, n == 0, n == 0});
      chk("wfull", {30'd0, wfull_f, wfull_r}, {30'd0, n == 16, n == 16});
      chk("walmost_full", {30'd0, wafull_f, wafull_r}, {30'd0, n >= 12, n >= 12});
      chk("ralmost_empty", {30'd0, raempty_f, raempty_r}, {30'd0, n <= 2, n <= 2});
      chk("overflow", {30'd0, ovf_f, ovf_r}, {30'd0, m_ovf, m_ovf});
      chk("underflow", {30'd0, udf_f, udf_r}, {30'd0, m_udf, m_udf});
      chk("rdata_fwft", 32'(rdata_f), 32'((n > 0) ? q[0] : m_last));
      chk("rdata_reg", 32'(rdata_r), 32'(m_last));
   endtask

   // One clock: apply inputs, let the edge happen, update the model, check.
   task automatic step(input bit w, input logic [7:0] d, input bit r,
                       input bit f = 0, input bit c = 0);
      bit full, empty;
      winc = w; wdata = d; rinc = r; flush = f; clr_err = c;
      @(posedge clk);
      full  = (q.size() == 16);
      empty = (q.size() == 0);
      if (f) q.delete();
      else begin
         if (r && !empty) m_last = q.pop_front();
         if (w && !full) q.push_back(d);
      end
      if (w && full && !f) m_ovf = 1; else if (c) m_ovf = 0;
      if (r && empty && !f) m_udf = 1; else if (c) m_udf = 0;
      #1;
      check_all();
      winc = 0; rinc = 0; flush = 0; clr_err = 0;
   endtask

   task automatic model_reset();
      q.delete(); m_last = '0; m_ovf = 0; m_udf = 0;
   endtask

   initial begin
      #13 rst_n = 1'b1;
      #1 check_all();

      // fill past full
      for (int i = 1; i <= 16; i++) step(1, 8'(i), 0);
      chk("full_at_16", 32'(wfull_f), 32'd1);
      step(1, 8'hEE, 0);
      chk("ovf_set", 32'(ovf_f), 32'd1);
      step(0, 0, 0, 0, 1);
      // drain past empty; the rejected write must not have landed
      for (int i = 1; i <= 16; i++) step(0, 0, 1);
      step(0, 0, 1);
      chk("udf_hold_10", 32'(rdata_f), 32'h10);
      step(0, 0, 0, 0, 1);

      // registered-read latency
      step(1, 8'hA5, 0);
      step(1, 8'h5A, 0);
      step(0, 0, 1);
      chk("reg_a5", 32'(rdata_r), 32'hA5);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      chk("reg_5a", 32'(rdata_r), 32'h5A);

      // simultaneous at count 8, full and empty
      for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0);
      for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1);
      chk("simul_cnt8", 32'(count_f), 32'd8);
      while (q.size() < 16) step(1, 8'($urandom), 0);
      step(1, 8'h77, 1);
      chk("simul_full", 32'(count_f), 32'd15);
      while (q.size() > 0) step(0, 0, 1);
      step(1, 8'h88, 1);
      chk("simul_empty", 32'(count_f), 32'd1);

      // set a sticky flag, then flush at count 10 with a write pending
      while (q.size() < 16) step(1, 8'($urandom), 0);
      step(1, 8'h99, 0);
      while (q.size() > 10) step(0, 0, 1);
      step(1, 8'hCC, 0, 1);
      chk("flush_ovf_kept", 32'(ovf_f), 32'd1);
      step(1, 8'h33, 0);
      step(0, 0, 1);
      chk("flush_33", 32'(rdata_r), 32'h33);
      step(1, 8'h44, 0, 0, 1);

      // set-wins on clr_err
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      chk("udf_set_wins", 32'(udf_f), 32'd1);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);

      // asynchronous reset mid-burst
      while (q.size() < 9) step(1, 8'($urandom), 0);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      #10 rst_n = 1'b1;
      #1 check_all();
      for (int i = 0; i < 40; i++)
         step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
